alu_operand_stage: RTL and testbench

//  ID->EX boundary register feeding the ALU's src1/src2/ALU_control inputs.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/operand_fwd_mux.sv | 36 +++
 rtl/alu_operand_stage.sv | 131 +++++++++++++
 tb/tb_alu_operand_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control encodings and default datapath widths.
package cpu_pkg;
  localparam int DW_DEF    = 32;
  localparam int RAW_DEF   = 5;
  localparam int CTRLW_DEF = 4;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
endpackage

// File: rtl/operand_fwd_mux.sv
// One ALU operand: EX/MEM-over-MEM/WB forwarding, then optional immediate select.
// Purely combinational; register x0 is never forwarded.
module operand_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int RAW = RAW_DEF
) (
  input  logic [RAW-1:0] rs_addr_i,
  input  logic [DW-1:0]  rs_data_i,
  input  logic           use_imm_i,
  input  logic [DW-1:0]  imm_i,
  input  logic           exmem_wr_i,
  input  logic [RAW-1:0] exmem_rd_i,
  input  logic [DW-1:0]  exmem_data_i,
  input  logic           memwb_wr_i,
  input  logic [RAW-1:0] memwb_rd_i,
  input  logic [DW-1:0]  memwb_data_i,
  output logic [DW-1:0]  opnd_o
);
  logic          rs_nz;
  logic [DW-1:0] fwd;

  assign rs_nz = (rs_addr_i != '0);

  always_comb begin
    fwd = rs_data_i;
    if (exmem_wr_i && rs_nz && (exmem_rd_i == rs_addr_i)) begin
      fwd = exmem_data_i;
    end else if (memwb_wr_i && rs_nz && (memwb_rd_i == rs_addr_i)) begin
      fwd = memwb_data_i;
    end
  end

  assign opnd_o = use_imm_i ? imm_i : fwd;
endmodule

// File: rtl/alu_operand_stage.sv
// ID->EX operand register: 2-entry in-order skid buffer, 1-cycle latency from capture to outputs.
// in_ready drops when full or on a load-use hazard; outputs hold while out_ready=0 or when empty.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RAW   = RAW_DEF,
  parameter int CTRLW = CTRLW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RAW-1:0]   rs1_addr,
  input  logic [RAW-1:0]   rs2_addr,
  input  logic [DW-1:0]    rs1_data,
  input  logic [DW-1:0]    rs2_data,
  input  logic [DW-1:0]    imm,
  input  logic             alu_src_imm,
  input  logic [CTRLW-1:0] alu_ctrl_in,
  input  logic [RAW-1:0]   rd_addr_in,
  input  logic             reg_write_in,
  input  logic             exmem_wr,
  input  logic [RAW-1:0]   exmem_rd,
  input  logic [DW-1:0]    exmem_data,
  input  logic             exmem_load,
  input  logic             memwb_wr,
  input  logic [RAW-1:0]   memwb_rd,
  input  logic [DW-1:0]    memwb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    src1,
  output logic [DW-1:0]    src2,
  output logic [CTRLW-1:0] ALU_control,
  output logic [RAW-1:0]   rd_addr_out,
  output logic             reg_write_out
);
  typedef struct packed {
    logic [DW-1:0]    s1;
    logic [DW-1:0]    s2;
    logic [CTRLW-1:0] ctrl;
    logic [RAW-1:0]   rd;
    logic             wr;
  } ent_t;

  ent_t       slot_q [2];
  ent_t       slot_d [2];
  ent_t       head_q, head_d, cap;
  logic [1:0] count_q, count_d;
  logic       wptr_q, wptr_d, rptr_q, rptr_d;
  logic       hold, push, pop;
  logic [DW-1:0] op1, op2;

  operand_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd1 (
    .rs_addr_i(rs1_addr), .rs_data_i(rs1_data), .use_imm_i(1'b0), .imm_i(imm),
    .exmem_wr_i(exmem_wr), .exmem_rd_i(exmem_rd), .exmem_data_i(exmem_data),
    .memwb_wr_i(memwb_wr), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
    .opnd_o(op1)
  );

  operand_fwd_mux #(.DW(DW), .RAW(RAW)) u_fwd2 (
    .rs_addr_i(rs2_addr), .rs_data_i(rs2_data), .use_imm_i(alu_src_imm), .imm_i(imm),
    .exmem_wr_i(exmem_wr), .exmem_rd_i(exmem_rd), .exmem_data_i(exmem_data),
    .memwb_wr_i(memwb_wr), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
    .opnd_o(op2)
  );

  // A load in EX/MEM cannot be forwarded yet; an immediate-form src2 does not depend on rs2.
  assign hold = exmem_load && (exmem_rd != '0) &&
                ((exmem_rd == rs1_addr) || (!alu_src_imm && (exmem_rd == rs2_addr)));

  assign in_ready  = !hold && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign cap = '{s1: op1, s2: op2, ctrl: alu_ctrl_in, rd: rd_addr_in, wr: reg_write_in};

  always_comb begin
    slot_d  = slot_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) begin
        slot_d[wptr_q] = cap;
        wptr_d         = ~wptr_q;
      end
      if (pop) begin
        rptr_d = ~rptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      // Head register is preloaded with the next head so outputs are pure flops.
      if (count_d != 2'd0) begin
        head_d = slot_d[rptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      head_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      head_q  <= head_d;
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign src1          = head_q.s1;
  assign src2          = head_q.s2;
  assign ALU_control   = head_q.ctrl;
  assign rd_addr_out   = head_q.rd;
  assign reg_write_out = head_q.wr;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table, directed corner sequences, random traffic vs queue model.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr_in, exmem_rd, memwb_rd, rd_addr_out;
  logic [31:0] rs1_data, rs2_data, imm, exmem_data, memwb_data, src1, src2;
  logic        alu_src_imm, reg_write_in, exmem_wr, exmem_load, memwb_wr;
  logic [3:0]  alu_ctrl_in, ALU_control;
  logic        out_valid, out_ready, reg_write_out;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .alu_src_imm(alu_src_imm), .alu_ctrl_in(alu_ctrl_in), .rd_addr_in(rd_addr_in),
    .reg_write_in(reg_write_in), .exmem_wr(exmem_wr), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .exmem_load(exmem_load), .memwb_wr(memwb_wr),
    .memwb_rd(memwb_rd), .memwb_data(memwb_data), .out_valid(out_valid),
    .out_ready(out_ready), .src1(src1), .src2(src2), .ALU_control(ALU_control),
    .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        w;
  } ent_t;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, im;
    logic        si, ew;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] md, e1, e2;
  } vec_t;

  ent_t q[$];
  ent_t last;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (exmem_wr && exmem_rd == a) return exmem_data;
    if (memwb_wr && memwb_rd == a) return memwb_data;
    return d;
  endfunction

  task automatic set_idle();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    alu_src_imm = 1'b0; alu_ctrl_in = ALU_ADD; rd_addr_in = '0; reg_write_in = 1'b0;
    exmem_wr = 1'b0; exmem_rd = '0; exmem_data = '0; exmem_load = 1'b0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  // One clock: predict readiness and the captured entry, advance the queue model, compare outputs.
  task automatic step();
    ent_t e;
    logic hold, rdy, push, pop;
    #1;
    hold = exmem_load && exmem_rd != 5'd0 &&
           (exmem_rd == rs1_addr || (!alu_src_imm && exmem_rd == rs2_addr));
    rdy  = !hold && (q.size() < 2);
    if (rst_n) chk("in_ready", 32'(in_ready), 32'(rdy));
    push = in_valid && rdy && !flush;
    pop  = (q.size() > 0) && out_ready;
    e.s1 = fwd(rs1_addr, rs1_data);
    e.s2 = alu_src_imm ? imm : fwd(rs2_addr, rs2_data);
    e.c  = alu_ctrl_in;
    e.rd = rd_addr_in;
    e.w  = reg_write_in;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      last = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("src1", src1, last.s1);
    chk("src2", src2, last.s2);
    chk("ALU_control", 32'(ALU_control), 32'(last.c));
    chk("rd_addr_out", 32'(rd_addr_out), 32'(last.rd));
    chk("reg_write_out", 32'(reg_write_out), 32'(last.w));
  endtask

  vec_t vt [7];

  initial begin
    clk = 1'b0;
    last = '0;
    vt[0] = '{5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd10, 32'd20};
    vt[1] = '{5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 5'd2, 32'd77, 1'b0, 5'd0, 32'd0, 32'd10, 32'd77};
    vt[2] = '{5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd55, 32'd55, 32'd20};
    vt[3] = '{5'd1, 5'd1, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 5'd1, 32'd66, 1'b1, 5'd1, 32'd55, 32'd66, 32'd66};
    vt[4] = '{5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 5'd1, 32'd66, 1'b1, 5'd1, 32'd55, 32'd55, 32'd20};
    vt[5] = '{5'd0, 5'd0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 5'd0, 32'd66, 1'b1, 5'd0, 32'd55, 32'd10, 32'd20};
    vt[6] = '{5'd3, 5'd2, 32'd10, 32'd20, 32'd1234, 1'b1, 1'b1, 5'd2, 32'd77, 1'b0, 5'd0, 32'd0, 32'd10, 32'd1234};

    // Reset held three edges with a valid entry offered.
    set_idle();
    rst_n = 1'b0; in_valid = 1'b1; rs1_data = 32'hDEAD; rd_addr_in = 5'd7; reg_write_in = 1'b1;
    repeat (3) step();
    set_idle();
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Forwarding vector table, buffer drained each time by out_ready=1.
    for (int i = 0; i < 7; i++) begin
      set_idle();
      in_valid = 1'b1; rd_addr_in = 5'(i + 1); reg_write_in = 1'b1; alu_ctrl_in = ALU_SUB;
      rs1_addr = vt[i].rs1; rs2_addr = vt[i].rs2; rs1_data = vt[i].d1; rs2_data = vt[i].d2;
      imm = vt[i].im; alu_src_imm = vt[i].si; exmem_wr = vt[i].ew; exmem_rd = vt[i].erd;
      exmem_data = vt[i].ed; memwb_wr = vt[i].mw; memwb_rd = vt[i].mrd; memwb_data = vt[i].md;
      step();
      chk($sformatf("vec%0d_src1", i), src1, vt[i].e1);
      chk($sformatf("vec%0d_src2", i), src2, vt[i].e2);
    end

    // EX/MEM beats MEM/WB on rs1.
    set_idle();
    in_valid = 1'b1; rs1_addr = 5'd5; rs1_data = 32'd1;
    exmem_wr = 1'b1; exmem_rd = 5'd5; exmem_data = 32'd7;
    memwb_wr = 1'b1; memwb_rd = 5'd5; memwb_data = 32'd9;
    step();
    chk("fwd_exmem_prio", src1, 32'd7);
    rs1_addr = 5'd0; rs1_data = 32'd123; exmem_rd = 5'd0; memwb_rd = 5'd0;
    step();
    chk("fwd_x0", src1, 32'd123);

    // Immediate overrides a matching forward on rs2.
    set_idle();
    in_valid = 1'b1; alu_src_imm = 1'b1; imm = 32'hFFFFFFFC; rs2_addr = 5'd6; rs2_data = 32'd8;
    exmem_wr = 1'b1; exmem_rd = 5'd6; exmem_data = 32'd99;
    step();
    chk("imm_src2", src2, 32'hFFFFFFFC);

    // Load-use hold for one cycle, then forward the now-available value.
    set_idle();
    in_valid = 1'b1; rs1_addr = 5'd3; rs1_data = 32'd2;
    exmem_wr = 1'b1; exmem_rd = 5'd3; exmem_load = 1'b1; exmem_data = 32'd0;
    #1;
    chk("loaduse_in_ready", 32'(in_ready), 32'd0);
    step();
    exmem_load = 1'b0; exmem_data = 32'd11;
    step();
    chk("loaduse_src1", src1, 32'd11);

    // Backpressure: fill with A,B, then drain in order.
    set_idle(); step(); step();
    out_ready = 1'b0; in_valid = 1'b1;
    rs1_data = 32'hA; step();
    rs1_data = 32'hB; step();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("held_A", src1, 32'hA);
    out_ready = 1'b1; step();
    chk("emit_B", src1, 32'hB);
    step();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_keeps_B", src1, 32'hB);

    // Flush while full with C offered, then flush at count 1 with E accepted that cycle.
    set_idle();
    out_ready = 1'b0; in_valid = 1'b1;
    rs1_data = 32'h11; step();
    rs1_data = 32'h22; step();
    rs1_data = 32'hC; flush = 1'b1; step();
    chk("flush_full_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_no_C", 32'(out_valid), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1;
    rs1_data = 32'hD; step();
    rs1_data = 32'hE; flush = 1'b1;
    #1;
    chk("flush_in_ready_ungated", 32'(in_ready), 32'd1);
    step();
    chk("flush_cnt1_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_no_E", 32'(out_valid), 32'd0);

    // Randomized traffic with small register space to provoke forwarding and hazards.
    for (int n = 0; n < 600; n++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      rs1_addr     = 5'($urandom_range(0, 3));
      rs2_addr     = 5'($urandom_range(0, 3));
      rs1_data     = $urandom;
      rs2_data     = $urandom;
      imm          = $urandom;
      alu_src_imm  = 1'($urandom_range(0, 1));
      alu_ctrl_in  = 4'($urandom_range(0, 15));
      rd_addr_in   = 5'($urandom_range(0, 31));
      reg_write_in = 1'($urandom_range(0, 1));
      exmem_wr     = 1'($urandom_range(0, 1));
      exmem_rd     = 5'($urandom_range(0, 3));
      exmem_data   = $urandom;
      exmem_load   = ($urandom_range(0, 5) == 0);
      memwb_wr     = 1'($urandom_range(0, 1));
      memwb_rd     = 5'($urandom_range(0, 3));
      memwb_data   = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
